// File: rtl/fault_list_builder.sv
// Collects per-row PE self-test results and keeps the worst faulty rows,
// sorted by faulty-PE count, with a total count and an overflow flag.
module fault_list_builder #(
  parameter int ARRAY_SIZE      = 8,
  parameter int NUM_FAULTY_ROWS = 2,
  parameter int ROW_ADDR_WIDTH  = 3,
  parameter int TOTAL_WIDTH     = 7
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      row_valid,
  input  logic [ARRAY_SIZE-1:0]                     row_fault_vec,
  output logic                                      row_ready,
  output logic [NUM_FAULTY_ROWS*ROW_ADDR_WIDTH-1:0] faulty_row_addr_flat,
  output logic [NUM_FAULTY_ROWS*ARRAY_SIZE-1:0]     faulty_pe_vec_flat,
  output logic [NUM_FAULTY_ROWS-1:0]                entry_valid,
  output logic [TOTAL_WIDTH-1:0]                    total_faulty_pes,
  output logic                                      overflow,
  output logic                                      busy,
  output logic                                      done
);

  localparam int N  = NUM_FAULTY_ROWS;
  localparam int AW = ROW_ADDR_WIDTH;
  localparam int CW = $clog2(ARRAY_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FINISH
  } state_t;

  state_t state;

  logic [AW-1:0]         addr_q [N];
  logic [ARRAY_SIZE-1:0] vec_q  [N];
  logic [CW-1:0]         cnt_q  [N];
  logic [N-1:0]          valid_q;
  logic [AW-1:0]         row_idx;

  logic [CW-1:0]         row_cnt;
  logic                  row_nonzero;
  logic                  list_full;
  logic                  last_row;
  logic [N-1:0]          ge;

  logic [AW-1:0]         nxt_addr  [N];
  logic [ARRAY_SIZE-1:0] nxt_vec   [N];
  logic [CW-1:0]         nxt_cnt   [N];
  logic [N-1:0]          nxt_valid;

  always_comb begin
    row_cnt = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      row_cnt = row_cnt + CW'(row_fault_vec[i]);
    end
  end

  assign row_nonzero = |row_fault_vec;
  assign list_full   = &valid_q;
  assign last_row    = (row_idx == AW'(ARRAY_SIZE - 1));

  // Valid entries form a sorted prefix, so ge is also a prefix; the new
  // row lands just past it and everything from there shifts up by one.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      ge[k] = valid_q[k] && (cnt_q[k] >= row_cnt);
    end
    if (ge[0]) begin
      nxt_addr[0]  = addr_q[0];
      nxt_vec[0]   = vec_q[0];
      nxt_cnt[0]   = cnt_q[0];
      nxt_valid[0] = valid_q[0];
    end else begin
      nxt_addr[0]  = row_idx;
      nxt_vec[0]   = row_fault_vec;
      nxt_cnt[0]   = row_cnt;
      nxt_valid[0] = 1'b1;
    end
    for (int k = 1; k < N; k++) begin
      if (ge[k]) begin
        nxt_addr[k]  = addr_q[k];
        nxt_vec[k]   = vec_q[k];
        nxt_cnt[k]   = cnt_q[k];
        nxt_valid[k] = valid_q[k];
      end else if (ge[k-1]) begin
        nxt_addr[k]  = row_idx;
        nxt_vec[k]   = row_fault_vec;
        nxt_cnt[k]   = row_cnt;
        nxt_valid[k] = 1'b1;
      end else begin
        nxt_addr[k]  = addr_q[k-1];
        nxt_vec[k]   = vec_q[k-1];
        nxt_cnt[k]   = cnt_q[k-1];
        nxt_valid[k] = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      row_ready        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      overflow         <= 1'b0;
      total_faulty_pes <= '0;
      row_idx          <= '0;
      valid_q          <= '0;
      for (int k = 0; k < N; k++) begin
        addr_q[k] <= '0;
        vec_q[k]  <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state            <= COLLECT;
            row_ready        <= 1'b1;
            busy             <= 1'b1;
            overflow         <= 1'b0;
            total_faulty_pes <= '0;
            row_idx          <= '0;
            valid_q          <= '0;
            for (int k = 0; k < N; k++) begin
              addr_q[k] <= '0;
              vec_q[k]  <= '0;
              cnt_q[k]  <= '0;
            end
          end
        end
        COLLECT: begin
          if (row_valid) begin
            total_faulty_pes <= total_faulty_pes + TOTAL_WIDTH'(row_cnt);
            row_idx          <= row_idx + 1'b1;
            if (row_nonzero) begin
              if (list_full) begin
                overflow <= 1'b1;
              end else begin
                valid_q <= nxt_valid;
                for (int k = 0; k < N; k++) begin
                  addr_q[k] <= nxt_addr[k];
                  vec_q[k]  <= nxt_vec[k];
                  cnt_q[k]  <= nxt_cnt[k];
                end
              end
            end
            if (last_row) begin
              state     <= FINISH;
              row_ready <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          row_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    faulty_row_addr_flat = '0;
    faulty_pe_vec_flat   = '0;
    for (int k = 0; k < N; k++) begin
      faulty_row_addr_flat[k*AW +: AW]               = addr_q[k];
      faulty_pe_vec_flat[k*ARRAY_SIZE +: ARRAY_SIZE] = vec_q[k];
    end
  end

  assign entry_valid = valid_q;

endmodule

// File: doc/fault_list_builder.md
FAULT_LIST_BUILDER -- requirements
Module: fault_list_builder

Interface
REQ-001 Parameter ARRAY_SIZE, default 8, number of PE rows and columns in the systolic array.
REQ-002 Parameter NUM_FAULTY_ROWS, default 2, number of fault-list entries.
REQ-003 Parameter ROW_ADDR_WIDTH, default 3, row address width; SHALL satisfy 2^ROW_ADDR_WIDTH >= ARRAY_SIZE.
REQ-004 Parameter TOTAL_WIDTH, default 7, width of the total faulty-PE count; SHALL hold ARRAY_SIZE*ARRAY_SIZE.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin a collection pass.
REQ-008 row_valid  input  1  row_fault_vec carries the self-test result of the next row.
REQ-009 row_fault_vec  input  ARRAY_SIZE  per-PE fault flags of the current row; bit j=1 means PE j is faulty.
REQ-010 row_ready  output  1  block accepts a row this cycle.
REQ-011 faulty_row_addr_flat  output  NUM_FAULTY_ROWS*ROW_ADDR_WIDTH  entry k address in bits [k*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH].
REQ-012 faulty_pe_vec_flat  output  NUM_FAULTY_ROWS*ARRAY_SIZE  entry k PE vector in bits [k*ARRAY_SIZE +: ARRAY_SIZE].
REQ-013 entry_valid  output  NUM_FAULTY_ROWS  bit k=1 when entry k holds a faulty row.
REQ-014 total_faulty_pes  output  TOTAL_WIDTH  sum of faulty PEs over all rows in the pass.
REQ-015 overflow  output  1  more faulty rows were seen than the list can hold.
REQ-016 busy  output  1  collection pass in progress.
REQ-017 done  output  1  one-cycle pulse; list is final.

Function
REQ-018 The FSM SHALL have three states: IDLE, COLLECT, FINISH.
REQ-019 IDLE: if start=1, clear entry_valid, total_faulty_pes, overflow and row index, then go to COLLECT; otherwise hold all outputs.
REQ-020 COLLECT: busy=1 and row_ready=1. A row is accepted when row_valid=1 and row_ready=1, and gets address equal to the row index.
REQ-021 Rows SHALL be accepted in order 0..ARRAY_SIZE-1. The row index increments by one per accepted row. row_valid=0 stalls the pass with no state change.
REQ-022 Per accepted row, popcount(row_fault_vec) SHALL be added to total_faulty_pes. The add is zero-extended and cannot wrap within a pass.
REQ-023 Any nonzero row with a free entry SHALL be inserted into the list. After insertion, valid entries are in descending popcount order. Ties keep arrival order: the earlier row sits at the lower index. Lower entries are unchanged; displaced entries shift up by one.
REQ-024 A nonzero row arriving when all NUM_FAULTY_ROWS entries are valid SHALL set overflow sticky. The list stays unchanged; that row's popcount is still added.
REQ-025 An all-zero row SHALL add no entry and leave overflow unchanged.
REQ-026 Accepting row ARRAY_SIZE-1 SHALL move to FINISH on the next edge. row_ready is 0 from that edge onward.
REQ-027 FINISH lasts exactly one cycle: done=1, busy=0, row_ready=0, then IDLE.
REQ-028 Latency from start to done is ARRAY_SIZE+1 cycles when row_valid is held high.
REQ-029 start is ignored in COLLECT and FINISH. start in the IDLE cycle right after FINISH begins a new pass.
REQ-030 List outputs, total_faulty_pes and overflow SHALL stay stable from done until the next accepted start.
REQ-031 Invalid entries SHALL drive address 0 and vector 0.
REQ-032 row_fault_vec SHALL be ignored whenever row_ready=0.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE from any state, including mid-COLLECT.
REQ-034 Reset values: all outputs 0, all entries invalid, row index 0.
REQ-035 Reset has priority over start and row_valid in the same cycle.
REQ-036 After reset, the next pass requires a new start; no partial pass is resumed.

Verification
REQ-037 All rows 0x00, row_valid held high -> done at cycle 9 after start; entry_valid=00, total=0, overflow=0.
REQ-038 Row 2=0x01, row 5=0x0F, rest 0:
- entry0 = addr 5, vec 0x0F; entry1 = addr 2, vec 0x01.
- entry_valid=11, total=5, overflow=0.
REQ-039 Rows 1=0x03, 4=0x81, 6=0xFF, rest 0:
- entry0 = addr 1, vec 0x03; entry1 = addr 4, vec 0x81 (tie kept in arrival order).
- overflow=1 at row 6, total=12.
REQ-040 row_valid toggled 1/0 each cycle with one faulty row 7=0x80 -> done 16 cycles after start; entry0 = addr 7, single entry, total=1.
REQ-041 rst asserted after row 3 of a pass with faults, then start reissued -> first cycle after reset shows all outputs 0. The new pass result is independent of the aborted one.
REQ-042 start pulsed during COLLECT and again in the cycle after done -> first is ignored (pass unaffected); second launches a pass and clears the previous list.
